// File: rtl/icache_pkg.sv
// icache_pkg: FSM state type and address-split width helpers shared by the icache_sa slice.
package icache_pkg;

  localparam int ADDR_W = 30;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    RESP
  } state_t;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int line_words);
    return ADDR_W - $clog2(sets) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: CPU fetch port plus memory refill burst port of icache_sa.
interface icache_if
  import icache_pkg::*;
();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              flush;
  logic [WORD_W-1:0] data;
  logic              resp_valid;
  logic              miss;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;

  // Cache side.
  modport slave (
    input  req, addr, flush, mem_ready, mem_rvalid, mem_rdata,
    output data, resp_valid, miss, mem_req, mem_addr
  );

  // Environment side: CPU fetch unit and backing instruction memory.
  modport master (
    output req, addr, flush, mem_ready, mem_rvalid, mem_rdata,
    input  data, resp_valid, miss, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_way.sv
// icache_way: one way of the cache: tag/valid/data storage, combinational tag compare and registered data read.
module icache_way
  import icache_pkg::*;
#(
  parameter int  SETS       = 64,
  parameter int  LINE_WORDS = 4,
  localparam int OFFSET_W   = offset_w(LINE_WORDS),
  localparam int INDEX_W    = index_w(SETS),
  localparam int TAG_W      = tag_w(SETS, LINE_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  input  logic [TAG_W-1:0]    rd_tag,
  output logic                hit,
  output logic [WORD_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                tag_we,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                inv_all,
  output logic                wr_valid
);

  logic [WORD_W-1:0] data_mem [SETS*LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [SETS-1:0]   valid_reg;
  logic [WORD_W-1:0] rd_data_reg;

  // Storage arrays carry no reset so they map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_reg <= data_mem[{rd_index, rd_offset}];
    end
    if (wr_en) begin
      data_mem[{wr_index, wr_offset}] <= wr_data;
    end
    if (tag_we) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  // Invalidate wins over a same-cycle line completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (inv_all) begin
      valid_reg <= '0;
    end else if (tag_we) begin
      valid_reg[wr_index] <= 1'b1;
    end
  end

  assign hit      = valid_reg[rd_index] && (tag_mem[rd_index] == rd_tag);
  assign rd_data  = rd_data_reg;
  assign wr_valid = valid_reg[wr_index];

endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative read-only instruction cache, one-cycle hits, whole-line refill on miss.
// Define ICACHE_PERF_EN to add the free-running hit_cnt/miss_cnt counter ports.
module icache_sa
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  icache_if.slave     bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(SETS, LINE_WORDS);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   req_addr_reg;
  logic [OFFSET_W-1:0] fill_cnt_reg;
  logic                flush_pend_reg;
  logic                hit_resp_reg;
  logic                hit_way_reg;
  logic [WORD_W-1:0]   crit_reg;
  logic [WORD_W-1:0]   data_reg;
  logic [SETS-1:0]     lru_reg;

  logic [INDEX_W-1:0]  lk_index, f_index;
  logic [OFFSET_W-1:0] lk_offset, f_offset;
  logic [TAG_W-1:0]    lk_tag, f_tag;
  logic [WAYS-1:0]     way_hit, way_wr_valid;
  logic [WORD_W-1:0]   way_rdata [WAYS];
  logic [WORD_W-1:0]   way_sel, data_out;
  logic                lookup_en, any_hit, lookup_hit, lookup_miss;
  logic                fill_we, last_beat, inv_all, hit_way, victim;

  assign lk_offset = bus.addr[OFFSET_W-1:0];
  assign lk_index  = bus.addr[OFFSET_W +: INDEX_W];
  assign lk_tag    = bus.addr[ADDR_W-1 -: TAG_W];
  assign f_offset  = req_addr_reg[OFFSET_W-1:0];
  assign f_index   = req_addr_reg[OFFSET_W +: INDEX_W];
  assign f_tag     = req_addr_reg[ADDR_W-1 -: TAG_W];

  // RESP also samples requests, so lookups happen in both IDLE and RESP.
  assign lookup_en   = bus.req && (state_reg == IDLE || state_reg == RESP);
  assign any_hit     = (|way_hit) && !bus.flush;
  assign lookup_hit  = lookup_en && any_hit;
  assign lookup_miss = lookup_en && !any_hit;
  assign hit_way     = (WAYS == 2) ? way_hit[WAYS-1] : 1'b0;

  assign fill_we   = (state_reg == FILL) && bus.mem_rvalid;
  assign last_beat = fill_we && (fill_cnt_reg == OFFSET_W'(LINE_WORDS - 1));
  // A flush seen during REQ/FILL takes effect together with the line completion.
  assign inv_all   = (bus.flush && (state_reg == IDLE || state_reg == RESP))
                   || (last_beat && (flush_pend_reg || bus.flush));

  // Victim: way 0 if invalid, else way 1 if invalid, else the LRU way.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!way_wr_valid[0]) begin
        victim = 1'b0;
      end else if (!way_wr_valid[WAYS-1]) begin
        victim = 1'b1;
      end else begin
        victim = lru_reg[f_index];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      icache_way #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
      ) u_way (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (lookup_en),
        .rd_index  (lk_index),
        .rd_offset (lk_offset),
        .rd_tag    (lk_tag),
        .hit       (way_hit[gi]),
        .rd_data   (way_rdata[gi]),
        .wr_en     (fill_we && (victim == 1'(gi))),
        .wr_index  (f_index),
        .wr_offset (fill_cnt_reg),
        .wr_data   (bus.mem_rdata),
        .tag_we    (last_beat && (victim == 1'(gi))),
        .wr_tag    (f_tag),
        .inv_all   (inv_all),
        .wr_valid  (way_wr_valid[gi])
      );
    end
  endgenerate

  always_comb begin
    way_sel = way_rdata[0];
    if (WAYS == 2 && hit_way_reg) begin
      way_sel = way_rdata[WAYS-1];
    end
  end

  always_comb begin
    state_next     = state_reg;
    bus.mem_req    = 1'b0;
    bus.miss       = 1'b0;
    bus.resp_valid = hit_resp_reg;
    data_out       = hit_resp_reg ? way_sel : data_reg;
    case (state_reg)
      IDLE: begin
        if (lookup_miss) begin
          state_next = REQ;
        end
      end
      REQ: begin
        bus.mem_req = 1'b1;
        bus.miss    = 1'b1;
        if (bus.mem_ready) begin
          state_next = FILL;
        end
      end
      FILL: begin
        bus.miss = 1'b1;
        if (last_beat) begin
          state_next = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        data_out       = crit_reg;
        state_next     = lookup_miss ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.data     = data_out;
  assign bus.mem_addr = {req_addr_reg[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      req_addr_reg   <= '0;
      fill_cnt_reg   <= '0;
      flush_pend_reg <= 1'b0;
      hit_resp_reg   <= 1'b0;
      hit_way_reg    <= 1'b0;
      crit_reg       <= '0;
      data_reg       <= '0;
      lru_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      data_reg       <= data_out;
      hit_resp_reg   <= lookup_hit;
      flush_pend_reg <= (state_reg == REQ || state_reg == FILL) && (flush_pend_reg || bus.flush);
      if (lookup_hit) begin
        hit_way_reg <= hit_way;
      end
      if (lookup_miss) begin
        req_addr_reg <= bus.addr;
      end
      if (fill_we) begin
        fill_cnt_reg <= fill_cnt_reg + 1'b1;
        if (fill_cnt_reg == f_offset) begin
          crit_reg <= bus.mem_rdata;
        end
      end
      // LRU bit names the way to evict next: always the one not just used.
      if (lookup_hit) begin
        lru_reg[lk_index] <= ~hit_way;
      end else if (last_beat) begin
        lru_reg[f_index] <= ~victim;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (lookup_hit) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (lookup_miss) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed plus randomized fetch traffic against a per-set recency-list model of icache_sa.
module tb_icache_sa;

  localparam int SETS = 64;
  localparam int WAYS = 2;
  localparam int LW   = 4;

  logic clk;
  logic rst;
  icache_if bus ();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_sa #(
    .SETS       (SETS),
    .WAYS       (WAYS),
    .LINE_WORDS (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model: each set keeps its resident line numbers, least recently used first.
  int unsigned set_q [SETS][$];
  int          m_hits   = 0;
  int          m_misses = 0;
  logic [31:0] last_data = '0;

  // Independent monitors of the bus.
  int refill_obs = 0;
  int hit_obs    = 0;
  bit miss_d     = 1'b0;

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ready && !rst) refill_obs <= refill_obs + 1;
    if (bus.resp_valid && !miss_d && !rst) hit_obs <= hit_obs + 1;
    miss_d <= bus.miss;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b00};
  endfunction

  function automatic bit model_access(input logic [29:0] a);
    int unsigned line;
    int unsigned s;
    line = 32'(a) / LW;
    s    = line % SETS;
    foreach (set_q[s][i]) begin
      if (set_q[s][i] == line) begin
        set_q[s].delete(i);
        set_q[s].push_back(line);
        m_hits++;
        return 1'b1;
      end
    end
    if (set_q[s].size() == WAYS) void'(set_q[s].pop_front());
    set_q[s].push_back(line);
    m_misses++;
    return 1'b0;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++) set_q[s].delete();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_data"}, bus.data, 32'h0);
    check_eq({tag, "_rvalid"}, 32'(bus.resp_valid), 32'h0);
    check_eq({tag, "_miss"}, 32'(bus.miss), 32'h0);
    check_eq({tag, "_memreq"}, 32'(bus.mem_req), 32'h0);
    check_eq({tag, "_memaddr"}, 32'(bus.mem_addr), 32'h0);
`ifdef ICACHE_PERF_EN
    check_eq({tag, "_hitcnt"}, hit_cnt, 32'h0);
    check_eq({tag, "_misscnt"}, miss_cnt, 32'h0);
`endif
  endtask

  task automatic idle_cycle();
    tick();
    check_eq("idle_rvalid", 32'(bus.resp_valid), 32'h0);
    check_eq("idle_hold", bus.data, last_data);
  endtask

  task automatic idle_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    model_flush();
    check_eq("flush_rvalid", 32'(bus.resp_valid), 32'h0);
    $display("flush (idle)");
  endtask

  // One fetch; returns whether the DUT answered it as a one-cycle hit.
  task automatic fetch(input logic [29:0] a, input int rdy_dly, input bit gaps,
                       input int flush_beat, input bit flush_req, input int rst_beat,
                       output bit obs_hit);
    bit          exp_hit;
    logic [29:0] base;
    if (flush_req) model_flush();
    exp_hit = model_access(a);
    base    = a & ~30'(LW - 1);
    bus.req   = 1'b1;
    bus.addr  = a;
    bus.flush = flush_req;
    tick();
    bus.req   = 1'b0;
    bus.flush = 1'b0;
    obs_hit   = bus.resp_valid;
    if (exp_hit) begin
      check_eq("hit_rvalid", 32'(bus.resp_valid), 32'h1);
      check_eq("hit_miss", 32'(bus.miss), 32'h0);
      check_eq("hit_data", bus.data, mem_word(a));
      last_data = mem_word(a);
      $display("fetch addr=%h hit data=%h", a, bus.data);
      return;
    end
    check_eq("miss_flag", 32'(bus.miss), 32'h1);
    check_eq("miss_rvalid", 32'(bus.resp_valid), 32'h0);
    check_eq("miss_memreq", 32'(bus.mem_req), 32'h1);
    check_eq("miss_memaddr", 32'(bus.mem_addr), 32'(base));
    for (int d = 0; d < rdy_dly; d++) begin
      tick();
      check_eq("wait_memreq", 32'(bus.mem_req), 32'h1);
      check_eq("wait_memaddr", 32'(bus.mem_addr), 32'(base));
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check_eq("req_drop", 32'(bus.mem_req), 32'h0);
    check_eq("fill_miss0", 32'(bus.miss), 32'h1);
    for (int k = 0; k < LW; k++) begin
      if (gaps) begin
        tick();
        check_eq("gap_miss", 32'(bus.miss), 32'h1);
      end
      if (k == rst_beat) begin
        rst            = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_word(base + 30'(k));
        tick();
        rst            = 1'b0;
        bus.mem_rvalid = 1'b0;
        model_flush();
        m_hits    = 0;
        m_misses  = 0;
        last_data = '0;
        check_zero_outputs("midfill_rst");
        $display("fetch addr=%h aborted by reset after %0d beats", a, k);
        return;
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_word(base + 30'(k));
      bus.flush      = (k == flush_beat);
      tick();
      bus.mem_rvalid = 1'b0;
      bus.flush      = 1'b0;
      if (k < LW - 1) begin
        check_eq("fill_miss", 32'(bus.miss), 32'h1);
        check_eq("fill_rvalid", 32'(bus.resp_valid), 32'h0);
      end else begin
        check_eq("resp_rvalid", 32'(bus.resp_valid), 32'h1);
        check_eq("resp_miss", 32'(bus.miss), 32'h0);
        check_eq("resp_data", bus.data, mem_word(a));
      end
    end
    if (flush_beat >= 0) model_flush();
    last_data = mem_word(a);
    $display("fetch addr=%h miss refilled line=%h data=%h", a, base, bus.data);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    bit          h;
    int          r0, h0;
    logic [29:0] a;
    int          sel;
    bus.req        = 1'b0;
    bus.addr       = '0;
    bus.flush      = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    rst            = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_zero_outputs("reset");

    // First fetch misses and refills; the neighbour word then hits.
    fetch(30'h000, 0, 0, -1, 0, -1, h);
    check_eq("first_is_miss", 32'(h), 32'h0);
    fetch(30'h001, 0, 0, -1, 0, -1, h);
    check_eq("second_is_hit", 32'(h), 32'h1);
    idle_cycle();

    // Sequential run over four lines from a cold cache.
    idle_flush();
    r0 = refill_obs;
    h0 = hit_obs;
    for (int i = 0; i < 16; i++) fetch(30'(i), 0, 0, -1, 0, -1, h);
    idle_cycle();
    check_eq("seq_refills", 32'(refill_obs - r0), 32'd4);
    check_eq("seq_hits", 32'(hit_obs - h0), 32'd12);

    // LRU: 0x200 displaces 0x100, not the recently used 0x000.
    fetch(30'h100, 0, 0, -1, 0, -1, h);
    fetch(30'h000, 0, 0, -1, 0, -1, h);
    fetch(30'h200, 0, 0, -1, 0, -1, h);
    fetch(30'h000, 0, 0, -1, 0, -1, h);
    check_eq("lru_keep", 32'(h), 32'h1);
    fetch(30'h100, 0, 0, -1, 0, -1, h);
    check_eq("lru_evict", 32'(h), 32'h0);

    // Slow memory: ready after 3 cycles, a gap before every beat.
    fetch(30'h053, 3, 1, -1, 0, -1, h);
    fetch(30'h052, 0, 0, -1, 0, -1, h);
    check_eq("slow_line_hit", 32'(h), 32'h1);

    // Flush during fill, then flush in IDLE, then flush together with a request.
    fetch(30'h040, 0, 0, 1, 0, -1, h);
    fetch(30'h040, 0, 0, -1, 0, -1, h);
    check_eq("flush_fill_refetch", 32'(h), 32'h0);
    idle_flush();
    fetch(30'h041, 0, 0, -1, 0, -1, h);
    check_eq("flush_idle_miss", 32'(h), 32'h0);
    fetch(30'h000, 0, 0, -1, 0, -1, h);
    check_eq("flush_idle_miss2", 32'(h), 32'h0);
    fetch(30'h042, 0, 0, -1, 1, -1, h);
    check_eq("flush_req_miss", 32'(h), 32'h0);
    idle_cycle();

    // Randomized traffic over a few conflicting sets and boundary tags.
    for (int n = 0; n < 250; n++) begin
      sel = int'($urandom_range(0, 3));
      a[29:8] = (sel == 3) ? 22'h3FFFFF : 22'(sel);
      sel = int'($urandom_range(0, 2));
      a[7:2]  = (sel == 2) ? 6'd63 : 6'(sel);
      a[1:0]  = 2'($urandom_range(0, 3));
      fetch(a, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, LW - 1)) : -1,
            1'($urandom_range(0, 24) == 0), -1, h);
      if ($urandom_range(0, 9) == 0) idle_cycle();
      if ($urandom_range(0, 39) == 0) idle_flush();
    end
`ifdef ICACHE_PERF_EN
    check_eq("rand_hitcnt", hit_cnt, 32'(m_hits));
    check_eq("rand_misscnt", miss_cnt, 32'(m_misses));
`endif

    // Reset in the middle of a refill, then the same line again.
    fetch(30'h080, 0, 0, -1, 0, -1, h);
    idle_cycle();
    fetch(30'h081, 0, 0, -1, 0, -1, h);
    fetch(30'h0C1, 0, 0, -1, 0, 2, h);
    fetch(30'h0C1, 0, 0, -1, 0, -1, h);
    check_eq("post_rst_miss", 32'(h), 32'h0);
    fetch(30'h0C2, 0, 0, -1, 0, -1, h);
    check_eq("post_rst_hit", 32'(h), 32'h1);
    fetch(30'h081, 0, 0, -1, 0, -1, h);
    check_eq("post_rst_cold", 32'(h), 32'h0);
    idle_cycle();
`ifdef ICACHE_PERF_EN
    check_eq("final_hitcnt", hit_cnt, 32'(m_hits));
    check_eq("final_misscnt", miss_cnt, 32'(m_misses));
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
